// File: rtl/hazard_response.sv
// Pipeline hazard response unit.
// Turns hazard-detector requests (load-use stall, taken jump, taken branch)
// and a data-memory busy indication into pipeline-register enables and
// flush controls. Control outputs are combinational (zero-latency); the
// unit also keeps saturating event counters and a sticky freeze watchdog.
module hazard_response #(
  parameter int CNT_W        = 32,
  parameter int FREEZE_LIMIT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_hazard,
  input  logic             ctrl_hazard_jump,
  input  logic             ctrl_hazard_branch,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             wdog_err
);

  // RUN: pipeline advancing (possibly stalled/flushed).
  // FREEZE: data memory busy, whole pipeline held.
  typedef enum logic {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } state_e;

  localparam logic [16:0] LIMIT = 17'(FREEZE_LIMIT);

  state_e           state_q, state_d;
  logic             pend_branch_q, pend_branch_d;
  logic             pend_jump_q, pend_jump_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [15:0]      frz_run_q, frz_run_d;
  logic             wdog_q, wdog_d;

  logic             branch_eff;
  logic             jump_eff;
  logic             stall_apply;
  logic             flush_apply;

  // Saturating increment: hold at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Effective control hazards and the events that drive the counters.
  // Pending flags only exist on the way out of FREEZE, so they are
  // qualified by that state.
  always_comb begin
    branch_eff  = ctrl_hazard_branch | (pend_branch_q & (state_q == FREEZE));
    jump_eff    = ctrl_hazard_jump   | (pend_jump_q   & (state_q == FREEZE));
    stall_apply = ~mem_busy & data_hazard & ~branch_eff;
    flush_apply = ~mem_busy & (branch_eff | (jump_eff & ~data_hazard));
  end

  // Zero-latency pipeline control, in priority order:
  // reset > memory freeze > branch squash > load-use stall > jump flush.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    if (reset) begin
      // Normal flow while in reset, whatever the inputs say.
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
    end else if (branch_eff) begin
      // The branch squashes the instruction that raised any data hazard,
      // so the PC is allowed to move to the branch target.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (data_hazard) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (jump_eff) begin
      ifid_flush = 1'b1;
    end
  end

  // Next-state for the FSM, pending flags, counters and watchdog.
  always_comb begin
    state_d       = mem_busy ? FREEZE : RUN;

    // Pulses seen during a freeze are remembered; the first un-frozen
    // cycle consumes them, so they clear whenever memory is not busy.
    pend_branch_d = mem_busy & (pend_branch_q | ctrl_hazard_branch);
    pend_jump_d   = mem_busy & (pend_jump_q   | ctrl_hazard_jump);

    stall_cnt_d   = stall_apply ? sat_inc(stall_cnt_q)  : stall_cnt_q;
    freeze_cnt_d  = mem_busy    ? sat_inc(freeze_cnt_q) : freeze_cnt_q;
    flush_cnt_d   = flush_apply ? sat_inc(flush_cnt_q)  : flush_cnt_q;

    // Consecutive-freeze length; saturates so a very long freeze cannot
    // wrap back below the limit.
    frz_run_d = 16'd0;
    if (mem_busy) begin
      frz_run_d = (&frz_run_q) ? frz_run_q : frz_run_q + 16'd1;
    end

    // Sticky: set on the cycle the run length reaches the limit.
    wdog_d = wdog_q | (mem_busy & (({1'b0, frz_run_q} + 17'd1) >= LIMIT));
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pend_branch_q <= 1'b0;
      pend_jump_q   <= 1'b0;
      stall_cnt_q   <= '0;
      freeze_cnt_q  <= '0;
      flush_cnt_q   <= '0;
      frz_run_q     <= '0;
      wdog_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q       <= state_d;
      pend_branch_q <= pend_branch_d;
      pend_jump_q   <= pend_jump_d;
      stall_cnt_q   <= stall_cnt_d;
      freeze_cnt_q  <= freeze_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      frz_run_q     <= frz_run_d;
      wdog_q        <= wdog_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign wdog_err   = wdog_q;

endmodule

// File: tb/tb_hazard_response.sv
// Testbench for hazard_response: directed vectors with hand-computed
// expectations, pushed into a scoreboard queue by the driver and popped by
// an independent monitor on the falling clock edge.
module tb_hazard_response;

  // Control vector order: {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write}
  localparam logic [5:0] NORM  = 6'b110101;
  localparam logic [5:0] FRZ   = 6'b000000;
  localparam logic [5:0] STALL = 6'b000111;
  localparam logic [5:0] BR    = 6'b111111;
  localparam logic [5:0] JMP   = 6'b111101;

  typedef struct {
    int         idx;
    logic [5:0] ctl;
    logic [3:0] s;
    logic [3:0] f;
    logic [3:0] l;
    logic       w;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       data_hazard;
  logic       ctrl_hazard_jump;
  logic       ctrl_hazard_branch;
  logic       mem_busy;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_write;
  logic       idex_flush;
  logic       exmem_write;
  logic [3:0] stall_cnt;
  logic [3:0] freeze_cnt;
  logic [3:0] flush_cnt;
  logic       wdog_err;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  hazard_response #(
    .CNT_W       (4),
    .FREEZE_LIMIT(4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .data_hazard       (data_hazard),
    .ctrl_hazard_jump  (ctrl_hazard_jump),
    .ctrl_hazard_branch(ctrl_hazard_branch),
    .mem_busy          (mem_busy),
    .pc_write          (pc_write),
    .ifid_write        (ifid_write),
    .ifid_flush        (ifid_flush),
    .idex_write        (idex_write),
    .idex_flush        (idex_flush),
    .exmem_write       (exmem_write),
    .stall_cnt         (stall_cnt),
    .freeze_cnt        (freeze_cnt),
    .flush_cnt         (flush_cnt),
    .wdog_err          (wdog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs (called just after a rising edge) and queue
  // the outputs expected during that cycle; counters/wdog are the values
  // registered by earlier cycles.
  task automatic step(input logic rst, input logic dh, input logic j, input logic b,
                      input logic mb, input logic [5:0] ctl,
                      input int s, input int f, input int l, input logic w);
    exp_t e;
    reset              = rst;
    data_hazard        = dh;
    ctrl_hazard_jump   = j;
    ctrl_hazard_branch = b;
    mem_busy           = mb;
    e.idx = step_no;
    e.ctl = ctl;
    e.s   = 4'(s);
    e.f   = 4'(f);
    e.l   = 4'(l);
    e.w   = w;
    q.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: the DUT presents a response every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check($sformatf("step%0d ctl", e.idx),
              32'({pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write}),
              32'(e.ctl));
        check($sformatf("step%0d stall_cnt", e.idx),  32'(stall_cnt),  32'(e.s));
        check($sformatf("step%0d freeze_cnt", e.idx), 32'(freeze_cnt), 32'(e.f));
        check($sformatf("step%0d flush_cnt", e.idx),  32'(flush_cnt),  32'(e.l));
        check($sformatf("step%0d wdog_err", e.idx),   32'(wdog_err),   32'(e.w));
      end
    end
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset              = 1'b1;
    data_hazard        = 1'b0;
    ctrl_hazard_jump   = 1'b0;
    ctrl_hazard_branch = 1'b0;
    mem_busy           = 1'b0;
    @(posedge clk);
    #1;

    //   rst dh j  b  mb  ctl    S  F  L  W
    // Reset forces normal flow regardless of inputs.
    step(1, 1, 1, 1, 1, NORM,  0, 0, 0, 0);
    step(0, 0, 0, 0, 0, NORM,  0, 0, 0, 0);
    // Single-cycle load-use stall.
    step(0, 1, 0, 0, 0, STALL, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, NORM,  1, 0, 0, 0);
    // Branch pulse.
    step(0, 0, 0, 1, 0, BR,    1, 0, 0, 0);
    step(0, 0, 0, 0, 0, NORM,  1, 0, 1, 0);
    // Jump pulse.
    step(0, 0, 1, 0, 0, JMP,   1, 0, 1, 0);
    step(0, 0, 0, 0, 0, NORM,  1, 0, 2, 0);
    // Jump ignored under a data hazard; no flush counted.
    step(0, 1, 1, 0, 0, STALL, 1, 0, 2, 0);
    step(0, 0, 0, 0, 0, NORM,  2, 0, 2, 0);
    // Branch beats data hazard: pc_write=1, stall not counted.
    step(0, 1, 0, 1, 0, BR,    2, 0, 2, 0);
    step(0, 0, 0, 0, 0, NORM,  2, 0, 3, 0);
    // Three-cycle freeze, branch in cycle 2, flush on cycle 4.
    step(0, 0, 0, 0, 1, FRZ,   2, 0, 3, 0);
    step(0, 0, 0, 1, 1, FRZ,   2, 1, 3, 0);
    step(0, 0, 0, 0, 1, FRZ,   2, 2, 3, 0);
    step(0, 0, 0, 0, 0, BR,    2, 3, 3, 0);
    step(0, 0, 0, 0, 0, NORM,  2, 3, 4, 0);
    // Jump held across a one-cycle freeze.
    step(0, 0, 1, 0, 1, FRZ,   2, 3, 4, 0);
    step(0, 0, 0, 0, 0, JMP,   2, 4, 4, 0);
    step(0, 0, 0, 0, 0, NORM,  2, 4, 5, 0);
    // Six-cycle freeze with limit 4: watchdog visible after the 4th.
    step(0, 0, 0, 0, 1, FRZ,   2, 4, 5, 0);
    step(0, 0, 0, 0, 1, FRZ,   2, 5, 5, 0);
    step(0, 0, 0, 0, 1, FRZ,   2, 6, 5, 0);
    step(0, 0, 0, 0, 1, FRZ,   2, 7, 5, 0);
    step(0, 0, 0, 0, 1, FRZ,   2, 8, 5, 1);
    step(0, 0, 0, 0, 1, FRZ,   2, 9, 5, 1);
    step(0, 0, 0, 0, 0, NORM,  2, 10, 5, 1);
    step(0, 0, 0, 0, 0, NORM,  2, 10, 5, 1);
    // Reset mid-freeze discards a pending branch and clears the watchdog.
    step(0, 0, 0, 1, 1, FRZ,   2, 10, 5, 1);
    step(1, 0, 0, 0, 1, NORM,  2, 11, 5, 1);
    step(0, 0, 0, 0, 0, NORM,  0, 0, 0, 0);
    // Twenty stall cycles: 4-bit stall counter saturates at 15.
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 0, 0, STALL, (i > 15) ? 15 : i, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0, NORM, 15, 0, 0, 0);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
